// File: rtl/gb_rom_loader_if.sv
// ROM byte stream in, Avalon-MM write master out.
// "master" is the loader side, "slave" the stream source / HPS slave side.
interface gb_rom_loader_if;
   logic [7:0]  s_data;
   logic        s_valid;
   logic        s_last;
   logic        s_ready;
   logic [25:0] m_address;
   logic        m_write;
   logic [7:0]  m_writedata;
   logic        m_waitrequest;

   modport master (
      input  s_data, s_valid, s_last, m_waitrequest,
      output s_ready, m_address, m_write, m_writedata
   );

   modport slave (
      output s_data, s_valid, s_last, m_waitrequest,
      input  s_ready, m_address, m_write, m_writedata
   );
endinterface

// File: rtl/gb_rom_loader.sv
// Streams a GameBoy ROM image into SDRAM through the cartridge HPS slave.
// Afterwards it zeroes cartridge RAM and writes the control block, releasing the core last.
module gb_rom_loader #(
   parameter logic [25:0] RAM_BASE = 26'h2000000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [7:0]            mbc_sel,
   input  logic [15:0]           num_rom_bank,
   input  logic [7:0]            num_ram_bank,
   input  logic                  double_speed_req,
   gb_rom_loader_if.master       bus,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [25:0]           rom_bytes
);
   typedef enum logic [2:0] {IDLE, LOCK, ROM, RAMCLR, CFG, DONE, ERR} state_t;

   localparam logic [25:0] CTRL_LOCK = RAM_BASE - 26'd1;
   localparam logic [25:0] CTRL_CFG0 = RAM_BASE - 26'd6;
   localparam logic [25:0] ROM_LIMIT = RAM_BASE - 26'd8;

   state_t      state_q, state_d;
   logic        wr_q, wr_d;
   logic [25:0] addr_q, addr_d;
   logic [7:0]  data_q, data_d;
   logic [25:0] rom_bytes_q, rom_bytes_d;
   logic        busy_q, busy_d, done_q, done_d, error_q, error_d;
   logic        last_q, last_d;
   logic [21:0] ram_cnt_q, ram_cnt_d;
   logic [2:0]  cfg_idx_q, cfg_idx_d;
   logic [7:0]  mbc_q, mbc_d, ram_bank_q, ram_bank_d;
   logic [15:0] rom_bank_q, rom_bank_d;
   logic        ds_q, ds_d;

   logic        wr_done, s_rdy, accept;
   logic [21:0] ram_last;

   assign wr_done  = wr_q & ~bus.m_waitrequest;
   assign s_rdy    = (state_q == ROM) & ~wr_q;
   assign accept   = s_rdy & bus.s_valid;
   assign ram_last = {1'b0, ram_bank_q, 13'b0} - 22'd1;

   // Control block contents, ordered so that the lock byte (0x01) goes out last.
   function automatic logic [7:0] cfg_byte(input logic [2:0] idx);
      case (idx)
         3'd0:    cfg_byte = {7'b0, ds_q};
         3'd1:    cfg_byte = mbc_q;
         3'd2:    cfg_byte = ram_bank_q;
         3'd3:    cfg_byte = rom_bank_q[7:0];
         3'd4:    cfg_byte = rom_bank_q[15:8];
         default: cfg_byte = 8'h01;
      endcase
   endfunction

   always_comb begin
      state_d     = state_q;
      wr_d        = wr_q;
      addr_d      = addr_q;
      data_d      = data_q;
      rom_bytes_d = rom_bytes_q;
      busy_d      = busy_q;
      done_d      = done_q;
      error_d     = error_q;
      last_d      = last_q;
      ram_cnt_d   = ram_cnt_q;
      cfg_idx_d   = cfg_idx_q;
      mbc_d       = mbc_q;
      ram_bank_d  = ram_bank_q;
      rom_bank_d  = rom_bank_q;
      ds_d        = ds_q;
      case (state_q)
         IDLE, DONE, ERR: if (start) begin
            mbc_d       = mbc_sel;
            ram_bank_d  = num_ram_bank;
            rom_bank_d  = num_rom_bank;
            ds_d        = double_speed_req;
            rom_bytes_d = '0;
            last_d      = 1'b0;
            busy_d      = 1'b1;
            done_d      = 1'b0;
            error_d     = 1'b0;
            wr_d        = 1'b1;
            addr_d      = CTRL_LOCK;
            data_d      = 8'h00;
            state_d     = LOCK;
         end
         LOCK: if (wr_done) begin
            wr_d    = 1'b0;
            state_d = ROM;
         end
         ROM: begin
            if (wr_done) begin
               wr_d        = 1'b0;
               rom_bytes_d = rom_bytes_q + 26'd1;
               if (last_q) begin
                  wr_d   = 1'b1;
                  data_d = 8'h00;
                  if (ram_bank_q == 8'd0) begin
                     cfg_idx_d = 3'd0;
                     addr_d    = CTRL_CFG0;
                     data_d    = cfg_byte(3'd0);
                     state_d   = CFG;
                  end else begin
                     ram_cnt_d = '0;
                     addr_d    = RAM_BASE;
                     state_d   = RAMCLR;
                  end
               end
            end else if (accept) begin
               // A byte that would spill into the control window aborts the load.
               if (rom_bytes_q >= ROM_LIMIT) begin
                  busy_d  = 1'b0;
                  error_d = 1'b1;
                  state_d = ERR;
               end else begin
                  wr_d   = 1'b1;
                  addr_d = rom_bytes_q;
                  data_d = bus.s_data;
                  last_d = bus.s_last;
               end
            end
         end
         RAMCLR: if (wr_done) begin
            if (ram_cnt_q == ram_last) begin
               cfg_idx_d = 3'd0;
               addr_d    = CTRL_CFG0;
               data_d    = cfg_byte(3'd0);
               state_d   = CFG;
            end else begin
               ram_cnt_d = ram_cnt_q + 22'd1;
               addr_d    = RAM_BASE + {4'b0, ram_cnt_q + 22'd1};
            end
         end
         CFG: if (wr_done) begin
            if (cfg_idx_q == 3'd5) begin
               wr_d    = 1'b0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = DONE;
            end else begin
               cfg_idx_d = cfg_idx_q + 3'd1;
               addr_d    = CTRL_CFG0 + {23'b0, cfg_idx_q + 3'd1};
               data_d    = cfg_byte(cfg_idx_q + 3'd1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_q        <= 1'b0;
         addr_q      <= '0;
         data_q      <= '0;
         rom_bytes_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         last_q      <= 1'b0;
         ram_cnt_q   <= '0;
         cfg_idx_q   <= '0;
         mbc_q       <= '0;
         ram_bank_q  <= '0;
         rom_bank_q  <= '0;
         ds_q        <= 1'b0;
      end else begin
         wr_q        <= wr_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         rom_bytes_q <= rom_bytes_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
         last_q      <= last_d;
         ram_cnt_q   <= ram_cnt_d;
         cfg_idx_q   <= cfg_idx_d;
         mbc_q       <= mbc_d;
         ram_bank_q  <= ram_bank_d;
         rom_bank_q  <= rom_bank_d;
         ds_q        <= ds_d;
      end
   end

   assign bus.s_ready     = s_rdy;
   assign bus.m_write     = wr_q;
   assign bus.m_address   = addr_q;
   assign bus.m_writedata = data_q;
   assign busy            = busy_q;
   assign done            = done_q;
   assign error           = error_q;
   assign rom_bytes       = rom_bytes_q;
endmodule

// File: tb/tb_gb_rom_loader.sv
// Directed bench for gb_rom_loader: a default-base instance plus a tiny-base one for the ROM limit.
module tb_gb_rom_loader;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic sel = 1'b0;
   logic start = 1'b0;
   logic [7:0] mbc_sel = '0, num_ram_bank = '0;
   logic [15:0] num_rom_bank = '0;
   logic double_speed_req = 1'b0;
   logic [7:0] s_data = '0;
   logic s_valid = 1'b0, s_last = 1'b0, wreq = 1'b0;

   always #5 clk = ~clk;

   gb_rom_loader_if ifa ();
   gb_rom_loader_if ifb ();
   logic busy_a, done_a, err_a, busy_b, done_b, err_b;
   logic [25:0] rb_a, rb_b;

   assign ifa.s_data = s_data;  assign ifb.s_data = s_data;
   assign ifa.s_last = s_last;  assign ifb.s_last = s_last;
   assign ifa.s_valid = s_valid & ~sel;
   assign ifb.s_valid = s_valid & sel;
   assign ifa.m_waitrequest = wreq;
   assign ifb.m_waitrequest = wreq;

   gb_rom_loader dut (
      .clk(clk), .reset(rst_n), .start(start & ~sel), .mbc_sel(mbc_sel),
      .num_rom_bank(num_rom_bank), .num_ram_bank(num_ram_bank),
      .double_speed_req(double_speed_req), .bus(ifa.master),
      .busy(busy_a), .done(done_a), .error(err_a), .rom_bytes(rb_a));

   gb_rom_loader #(.RAM_BASE(26'h40)) dut_s (
      .clk(clk), .reset(rst_n), .start(start & sel), .mbc_sel(mbc_sel),
      .num_rom_bank(num_rom_bank), .num_ram_bank(num_ram_bank),
      .double_speed_req(double_speed_req), .bus(ifb.master),
      .busy(busy_b), .done(done_b), .error(err_b), .rom_bytes(rb_b));

   wire        s_ready_m = sel ? ifb.s_ready : ifa.s_ready;
   wire        m_write_m = sel ? ifb.m_write : ifa.m_write;
   wire [25:0] m_addr_m  = sel ? ifb.m_address : ifa.m_address;
   wire [7:0]  m_data_m  = sel ? ifb.m_writedata : ifa.m_writedata;
   wire        busy_m = sel ? busy_b : busy_a;
   wire        done_m = sel ? done_b : done_a;
   wire        err_m  = sel ? err_b : err_a;
   wire [25:0] rb_m   = sel ? rb_b : rb_a;

   typedef struct packed {logic [25:0] a; logic [7:0] d;} wr_t;
   wr_t wq[$];

   // Inputs change 1ns after posedge, so the mid-cycle view is what the next edge sees.
   always @(negedge clk) if (rst_n && m_write_m && !wreq) wq.push_back({m_addr_m, m_data_m});

   int checks = 0, errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   function automatic wr_t get(input int k);
      if (k < wq.size()) return wq[k];
      return '1;
   endfunction

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic l);
      int n;
      s_valid = 1'b1; s_data = b; s_last = l; n = 0;
      @(negedge clk);
      while (!s_ready_m && n < 500) begin @(negedge clk); n++; end
      if (!s_ready_m) chk("s_ready_timeout", 0, 1);
      @(posedge clk); #1;
      s_valid = 1'b0; s_last = 1'b0;
   endtask

   task automatic wait_end();
      int n = 0;
      while (!(done_m || err_m) && n < 20000) begin @(negedge clk); n++; end
      if (!(done_m || err_m)) chk("finish_timeout", 0, 1);
   endtask

   // Stall the write of ROM byte 2 for five cycles and watch it hold.
   task automatic stall_byte2();
      int n = 0;
      @(negedge clk);
      while (!(s_valid && s_ready_m && rb_m == 26'd2) && n < 500) begin @(negedge clk); n++; end
      if (n >= 500) chk("stall_arm_timeout", 0, 1);
      @(posedge clk); #1;
      wreq = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("stall_addr", {m_write_m, m_addr_m}, {1'b1, 26'd2});
         chk("stall_data", m_data_m, 8'hA2);
         chk("stall_s_ready", s_ready_m, 0);
         @(posedge clk); #1;
      end
      wreq = 1'b0;
   endtask

   task automatic run_load(input logic [7:0] mbc, input logic [15:0] nrom, input logic [7:0] nram,
                           input logic ds, input int nbytes, input bit stall, input bit gap, input bit poke);
      wq.delete();
      mbc_sel = mbc; num_rom_bank = nrom; num_ram_bank = nram; double_speed_req = ds;
      pulse_start();
      fork
         begin
            for (int i = 0; i < nbytes; i++) begin
               send_byte(8'hA0 + 8'(i), i == nbytes - 1);
               if (poke && i == 0) begin
                  pulse_start();
                  chk("poke_busy", busy_m, 1);
               end
               if (gap && i == 1) begin
                  int n0;
                  repeat (2) @(posedge clk);
                  n0 = wq.size();
                  repeat (10) @(posedge clk);
                  #1;
                  chk("gap_no_writes", wq.size(), n0);
               end
            end
         end
         begin
            if (stall) stall_byte2();
         end
      join
      wait_end();
   endtask

   task automatic check_load(input string tag, input int nbytes, input int nram, input logic [7:0] cfg [6]);
      int base, bad;
      chk({tag, "_lock"}, get(0), {26'h1FFFFFF, 8'h00});
      for (int i = 0; i < nbytes; i++) chk({tag, "_rom"}, get(1 + i), {26'(i), 8'hA0 + 8'(i)});
      base = 1 + nbytes;
      if (nram != 0) begin
         bad = 0;
         for (int j = 0; j < nram * 8192; j++)
            if (get(base + j) !== {26'h2000000 + 26'(j), 8'h00}) bad++;
         chk({tag, "_ramclr_bad"}, bad, 0);
         base += nram * 8192;
      end
      for (int k = 0; k < 6; k++) chk({tag, "_cfg"}, get(base + k), {26'h1FFFFFA + 26'(k), cfg[k]});
      chk({tag, "_nwrites"}, wq.size(), base + 6);
      chk({tag, "_status"}, {busy_m, done_m, err_m}, 3'b010);
      chk({tag, "_rom_bytes"}, rb_m, nbytes);
   endtask

   typedef struct {
      logic [7:0]  mbc;
      logic [15:0] nrom;
      logic        ds;
      int          nbytes;
      bit          stall, gap, poke;
      logic [7:0]  cfg [6];
   } vec_t;

   vec_t tbl [4];

   initial begin
      logic [7:0] cfg_ram [6];
      int n;
      tbl[0] = '{8'h01, 16'h0102, 1'b0, 4, 1'b0, 1'b0, 1'b0, '{8'h00, 8'h01, 8'h00, 8'h02, 8'h01, 8'h01}};
      tbl[1] = '{8'h01, 16'h0102, 1'b0, 4, 1'b1, 1'b0, 1'b0, '{8'h00, 8'h01, 8'h00, 8'h02, 8'h01, 8'h01}};
      tbl[2] = '{8'h1B, 16'h0040, 1'b1, 5, 1'b0, 1'b1, 1'b0, '{8'h01, 8'h1B, 8'h00, 8'h40, 8'h00, 8'h01}};
      tbl[3] = '{8'hFF, 16'hFFFF, 1'b0, 3, 1'b0, 1'b0, 1'b1, '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h01}};
      cfg_ram = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h01, 8'h01};

      repeat (2) @(negedge clk);
      chk("reset_status", {busy_a, done_a, err_a, ifa.m_write, ifa.s_ready}, 5'b0);
      chk("reset_addr", ifa.m_address, 0);
      chk("reset_data", ifa.m_writedata, 0);
      chk("reset_rom_bytes", rb_a, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int v = 0; v < 4; v++) begin
         run_load(tbl[v].mbc, tbl[v].nrom, 8'd0, tbl[v].ds, tbl[v].nbytes,
                  tbl[v].stall, tbl[v].gap, tbl[v].poke);
         check_load($sformatf("vec%0d", v), tbl[v].nbytes, 0, tbl[v].cfg);
      end

      run_load(8'h01, 16'h0102, 8'd1, 1'b0, 2, 1'b0, 1'b0, 1'b0);
      check_load("ram1", 2, 1, cfg_ram);

      // Reset in the middle of the RAM clear, then a clean load.
      wq.delete();
      mbc_sel = 8'h01; num_rom_bank = 16'h0102; num_ram_bank = 8'd1; double_speed_req = 1'b0;
      pulse_start();
      send_byte(8'hA0, 1'b0);
      send_byte(8'hA1, 1'b1);
      n = 0;
      while (m_addr_m != 26'h2000010 && n < 1000) begin @(negedge clk); n++; end
      chk("ramclr_reached", m_addr_m, 26'h2000010);
      #2 rst_n = 1'b0;
      #1;
      chk("midreset_status", {busy_a, done_a, err_a, ifa.m_write, ifa.s_ready}, 5'b0);
      chk("midreset_addr", ifa.m_address, 0);
      chk("midreset_data", ifa.m_writedata, 0);
      chk("midreset_rom_bytes", rb_a, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_load(tbl[0].mbc, tbl[0].nrom, 8'd0, tbl[0].ds, 4, 1'b0, 1'b0, 1'b0);
      check_load("after_reset", 4, 0, tbl[0].cfg);

      // Tiny RAM_BASE: control window starts at 0x3A, ROM limit at 0x38.
      sel = 1'b1;
      wq.delete();
      pulse_start();
      for (int i = 0; i < 60; i++) begin
         if (err_m) break;
         send_byte(8'(i), i == 59);
      end
      repeat (4) @(posedge clk);
      #1;
      chk("lim_status", {busy_m, done_m, err_m, s_ready_m}, 4'b0010);
      chk("lim_rom_bytes", rb_m, 56);
      chk("lim_nwrites", wq.size(), 57);
      chk("lim_lock", get(0), {26'h3F, 8'h00});
      n = 0;
      for (int i = 0; i < 56; i++) if (get(1 + i) !== {26'(i), 8'(i)}) n++;
      chk("lim_rom_bad", n, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
